// File: rtl/weight_outlier_pkg.sv
// Shared types and helpers for the weight outlier extract/repack path.
// Also used by the weight loader, so keep the range-check semantics stable.
package weight_outlier_pkg;

  localparam int N_CH_DEF   = 8;
  localparam int W_LO_DEF   = 4;
  // Slot indices are carried at a fixed width wide enough for any supported channel count.
  localparam int SLOT_IDX_W = 8;

  typedef struct packed {
    logic                  sel;
    logic [SLOT_IDX_W-1:0] src;
    logic [SLOT_IDX_W-1:0] dst;
  } slot_t;

  function automatic logic idx_in_range(input logic [SLOT_IDX_W-1:0] idx, input int n_ch);
    return ({24'd0, idx} < 32'(n_ch));
  endfunction

endpackage

// File: rtl/wop_pipe_reg.sv
// One valid/ready register stage; data only moves on a handshake so it is
// bit-stable while the consumer stalls.
module wop_pipe_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          v_q;
  logic          v_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;

  always_comb begin
    in_ready = !v_q || out_ready;
    v_d      = v_q;
    data_d   = data_q;
    if (in_ready) begin
      v_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign out_valid = v_q;
  assign out_data  = data_q;

endmodule

// File: rtl/weight_outlier_packer.sv
// Outlier extract/repack stage: zeroes selected channels and re-inserts their values as high halves.
// Optional feature macro: OUTLIER_STATS_EN adds the stat_outliers counter output.
module weight_outlier_packer
  import weight_outlier_pkg::*;
#(
  parameter  int N_CH  = N_CH_DEF,
  parameter  int W_LO  = W_LO_DEF,
  parameter  int N_OUT = 2,
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_CH*W_LO-1:0]    in_weights,
  input  logic [N_OUT-1:0]        in_sel,
  input  logic [N_OUT*IDX_W-1:0]  in_src_idx,
  input  logic [N_OUT*IDX_W-1:0]  in_dst_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_CH*2*W_LO-1:0]  out_weights,
  output logic                    err_collide,
  output logic                    err_range
`ifdef OUTLIER_STATS_EN
  ,
  output logic [31:0]             stat_outliers
`endif
);

  localparam int LO_W  = N_CH * W_LO;
  localparam int CUT_W = N_OUT * W_LO;
  localparam int DST_W = N_OUT * IDX_W;
  localparam int S1_W  = DST_W + N_OUT + CUT_W + LO_W;
  localparam int OUT_W = N_CH * 2 * W_LO;
`ifdef OUTLIER_STATS_EN
  localparam int S2_W  = N_OUT + OUT_W;
`else
  localparam int S2_W  = OUT_W;
`endif

  slot_t              slot [N_OUT];
  logic [N_OUT-1:0]   slot_ok;
  logic [LO_W-1:0]    lo_vec;
  logic [CUT_W-1:0]   cut_vec;
  logic [DST_W-1:0]   dst_vec;
  logic               collide;
  logic               range_bad;

  // Capture happens before zeroing, so two slots sharing a src both see the original value.
  always_comb begin
    slot_ok   = '0;
    lo_vec    = in_weights;
    cut_vec   = '0;
    dst_vec   = in_dst_idx;
    collide   = 1'b0;
    range_bad = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      slot[k].sel = in_sel[k];
      slot[k].src = SLOT_IDX_W'(in_src_idx[k*IDX_W +: IDX_W]);
      slot[k].dst = SLOT_IDX_W'(in_dst_idx[k*IDX_W +: IDX_W]);
      slot_ok[k]  = slot[k].sel && idx_in_range(slot[k].src, N_CH)
                                && idx_in_range(slot[k].dst, N_CH);
      range_bad   = range_bad | (slot[k].sel && !slot_ok[k]);
      for (int c = 0; c < N_CH; c++) begin
        if (slot[k].src == SLOT_IDX_W'(c))
          cut_vec[k*W_LO +: W_LO] = in_weights[c*W_LO +: W_LO];
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (slot_ok[k] && slot[k].src == SLOT_IDX_W'(c))
          lo_vec[c*W_LO +: W_LO] = '0;
      end
    end
    for (int j = 0; j < N_OUT; j++) begin
      for (int k = j + 1; k < N_OUT; k++) begin
        if (slot_ok[j] && slot_ok[k] && slot[j].dst == slot[k].dst)
          collide = 1'b1;
      end
    end
  end

  logic            err_collide_q;
  logic            err_collide_d;
  logic            err_range_q;
  logic            err_range_d;

  always_comb begin
    err_collide_d = err_collide_q;
    err_range_d   = err_range_q;
    if (in_valid && in_ready) begin
      err_collide_d = err_collide_q | collide;
      err_range_d   = err_range_q | range_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_collide_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      err_collide_q <= err_collide_d;
      err_range_q   <= err_range_d;
    end
  end

  assign err_collide = err_collide_q;
  assign err_range   = err_range_q;

  logic [S1_W-1:0] s1_din;
  logic [S1_W-1:0] s1_data;
  logic            s1_valid;
  logic            s2_in_ready;

  assign s1_din = {dst_vec, slot_ok, cut_vec, lo_vec};

  wop_pipe_reg #(.DW(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_din),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  logic [LO_W-1:0]  s1_lo;
  logic [CUT_W-1:0] s1_cut;
  logic [N_OUT-1:0] s1_ok;
  logic [DST_W-1:0] s1_dst;
  logic [OUT_W-1:0] merged;
  logic [W_LO-1:0]  hi_val;
  logic             hi_found;

  assign s1_lo  = s1_data[LO_W-1:0];
  assign s1_cut = s1_data[LO_W +: CUT_W];
  assign s1_ok  = s1_data[LO_W+CUT_W +: N_OUT];
  assign s1_dst = s1_data[LO_W+CUT_W+N_OUT +: DST_W];

  // Ascending slot scan with a found flag gives the lowest enabled slot priority on a shared dst.
  always_comb begin
    merged   = '0;
    hi_val   = '0;
    hi_found = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      hi_val   = '0;
      hi_found = 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        if (!hi_found && s1_ok[k] && s1_dst[k*IDX_W +: IDX_W] == IDX_W'(c)) begin
          hi_val   = s1_cut[k*W_LO +: W_LO];
          hi_found = 1'b1;
        end
      end
      merged[c*2*W_LO +: 2*W_LO] = {hi_val, s1_lo[c*W_LO +: W_LO]};
    end
  end

  logic [S2_W-1:0] s2_din;
  logic [S2_W-1:0] s2_data;

`ifdef OUTLIER_STATS_EN
  assign s2_din = {s1_ok, merged};
`else
  assign s2_din = merged;
`endif

  wop_pipe_reg #(.DW(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_weights = s2_data[OUT_W-1:0];

`ifdef OUTLIER_STATS_EN
  logic [31:0]      stat_q;
  logic [31:0]      stat_d;
  logic [32:0]      stat_sum;
  logic [N_OUT-1:0] s2_ok;

  assign s2_ok = s2_data[OUT_W +: N_OUT];

  always_comb begin
    stat_sum = {1'b0, stat_q};
    if (out_valid && out_ready) begin
      for (int k = 0; k < N_OUT; k++)
        stat_sum = stat_sum + 33'(s2_ok[k]);
    end
    stat_d = stat_sum[32] ? '1 : stat_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_outliers = stat_q;
`endif

endmodule

// File: tb/tb_weight_outlier_packer.sv
// Directed bench for weight_outlier_packer: an 8-channel and a 6-channel instance.
module tb_weight_outlier_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_weights;
  logic [1:0]  in_sel;
  logic [5:0]  in_src_idx;
  logic [5:0]  in_dst_idx;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_weights;
  logic        err_collide;
  logic        err_range;

  logic        in6_valid;
  logic        in6_ready;
  logic [23:0] in6_weights;
  logic [1:0]  in6_sel;
  logic [5:0]  in6_src_idx;
  logic [5:0]  in6_dst_idx;
  logic        out6_valid;
  logic        out6_ready;
  logic [47:0] out6_weights;
  logic        err6_collide;
  logic        err6_range;
`ifdef OUTLIER_STATS_EN
  logic [31:0] stat8;
  logic [31:0] stat6;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_outlier_packer #(.N_CH(8), .W_LO(4), .N_OUT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_weights  (in_weights),
    .in_sel      (in_sel),
    .in_src_idx  (in_src_idx),
    .in_dst_idx  (in_dst_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_weights (out_weights),
    .err_collide (err_collide),
    .err_range   (err_range)
`ifdef OUTLIER_STATS_EN
    ,
    .stat_outliers (stat8)
`endif
  );

  weight_outlier_packer #(.N_CH(6), .W_LO(4), .N_OUT(2)) dut6 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in6_valid),
    .in_ready    (in6_ready),
    .in_weights  (in6_weights),
    .in_sel      (in6_sel),
    .in_src_idx  (in6_src_idx),
    .in_dst_idx  (in6_dst_idx),
    .out_valid   (out6_valid),
    .out_ready   (out6_ready),
    .out_weights (out6_weights),
    .err_collide (err6_collide),
    .err_range   (err6_range)
`ifdef OUTLIER_STATS_EN
    ,
    .stat_outliers (stat6)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one beat for one cycle; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [31:0] w, input logic [1:0] sel,
                               input logic [2:0] s0, input logic [2:0] d0,
                               input logic [2:0] s1, input logic [2:0] d1);
    in_weights = w;
    in_sel     = sel;
    in_src_idx = {s1, s0};
    in_dst_idx = {d1, d0};
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  task automatic sendAndCheck(input string tag, input logic [31:0] w, input logic [1:0] sel,
                              input logic [2:0] s0, input logic [2:0] d0,
                              input logic [2:0] s1, input logic [2:0] d1,
                              input logic [63:0] exp);
    applyStimulus(w, sel, s0, d0, s1, d1);
    checkOutput({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_data"}, out_weights, exp);
    @(negedge clk);
  endtask

  function automatic logic [31:0] stream_w(input int i);
    return 32'h7654_3210 + 32'h1111_1111 * 32'(i);
  endfunction

  function automatic logic [63:0] expand(input logic [31:0] w);
    logic [63:0] r;
    r = '0;
    for (int c = 0; c < 8; c++) r[c*8 +: 8] = {4'h0, w[c*4 +: 4]};
    return r;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int sent;
    int rcvd;
    int cyc;
    logic held;
    logic [63:0] held_val;

    rst = 1'b1;
    in_valid = 1'b0; in_weights = '0; in_sel = '0; in_src_idx = '0; in_dst_idx = '0;
    out_ready = 1'b1;
    in6_valid = 1'b0; in6_weights = '0; in6_sel = '0; in6_src_idx = '0; in6_dst_idx = '0;
    out6_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_weights", out_weights, 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_err_collide", 64'(err_collide), 64'd0);
    checkOutput("rst_err_range", 64'(err_range), 64'd0);

    // Single outlier: ch2 (value 3) moves to the high half of lane 5.
    sendAndCheck("t1", 32'h8765_4321, 2'b01, 3'd2, 3'd5, 3'd0, 3'd0, 64'h0807_3605_0400_0201);
    checkOutput("t1_no_collide", 64'(err_collide), 64'd0);

    // Shared dst: slot0 (0xA) wins lane 3, slot1 value dropped but its src still zeroed.
    sendAndCheck("t2", 32'hF654_321A, 2'b11, 3'd0, 3'd3, 3'd7, 3'd3, 64'h0006_0504_A302_0100);
    checkOutput("t2_err_collide", 64'(err_collide), 64'd1);
    checkOutput("t2_err_range", 64'(err_range), 64'd0);

    sendAndCheck("t4_same", 32'h7659_3210, 2'b01, 3'd4, 3'd4, 3'd0, 3'd0, 64'h0706_0590_0302_0100);
    sendAndCheck("t4_none", 32'hFEDC_BA98, 2'b00, 3'd7, 3'd1, 3'd6, 3'd2, 64'h0F0E_0D0C_0B0A_0908);
    sendAndCheck("t4_slot1", 32'h8765_4321, 2'b10, 3'd0, 3'd0, 3'd1, 3'd6, 64'h0827_0605_0403_0001);
    sendAndCheck("t4_same_src", 32'h8765_4321, 2'b11, 3'd3, 3'd0, 3'd3, 3'd7, 64'h4807_0605_0003_0241);
    checkOutput("collide_sticky", 64'(err_collide), 64'd1);

    // Back-to-back stream under a stalling consumer.
    sent = 0; rcvd = 0; cyc = 0; held = 1'b0; held_val = '0;
    in_sel = 2'b00;
    while (rcvd < 10 && cyc < 200) begin
      out_ready = pat[cyc % 7][0];
      if (sent < 10) begin
        in_valid   = 1'b1;
        in_weights = stream_w(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (held) checkOutput("stall_hold", out_weights, held_val);
        if (out_ready) begin
          checkOutput("stream_data", out_weights, expand(stream_w(rcvd)));
          rcvd++;
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_val = out_weights;
        end
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_count", 64'(rcvd), 64'd10);
    checkOutput("stream_sent", 64'(sent), 64'd10);
    repeat (2) @(negedge clk);
    checkOutput("stream_no_dup", 64'(out_valid), 64'd0);

    // Fill both stages, then reset.
    out_ready  = 1'b0;
    in_sel     = 2'b00;
    in_valid   = 1'b1;
    in_weights = 32'h1111_1111;
    @(negedge clk);
    in_weights = 32'h2222_2222;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_out_weights", out_weights, 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid_rst_err_collide", 64'(err_collide), 64'd0);
    checkOutput("mid_rst_err_range", 64'(err_range), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_idle", 64'(out_valid), 64'd0);

    // Six channels: slot0 dst=7 is out of range and ignored, slot1 ch2 -> lane 4.
    checkOutput("t6_rst_err_range", 64'(err6_range), 64'd0);
    in6_weights = 24'h65_4321;
    in6_sel     = 2'b11;
    in6_src_idx = {3'd2, 3'd1};
    in6_dst_idx = {3'd4, 3'd7};
    in6_valid   = 1'b1;
    @(negedge clk);
    in6_valid = 1'b0;
    @(negedge clk);
    checkOutput("t6_valid", 64'(out6_valid), 64'd1);
    checkOutput("t6_data", 64'(out6_weights), 64'h0000_0635_0400_0201);
    checkOutput("t6_err_range", 64'(err6_range), 64'd1);
    checkOutput("t6_err_collide", 64'(err6_collide), 64'd0);
    @(negedge clk);
`ifdef OUTLIER_STATS_EN
    checkOutput("t6_stat", 64'(stat6), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
